// File: rtl/mod_mem_arbiter.sv
// Two-requester (I/D) arbiter onto a single downstream memory bus, one outstanding.
// Define MEMARB_ROUND_ROBIN_EN for round-robin; default build gives D fixed priority.
module mod_mem_arbiter #(
  parameter int ADDRWIDTH = 64,
  parameter int BLOCKBITS = 512,
  parameter int TAGWIDTH  = 13
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [ADDRWIDTH-1:0] s_i_req,
  input  logic [TAGWIDTH-1:0]  s_i_reqtag,
  input  logic [BLOCKBITS-1:0] s_i_reqdata,
  input  logic                 s_i_reqcyc,
  output logic                 s_i_reqack,
  output logic [BLOCKBITS-1:0] s_i_resp,
  output logic [TAGWIDTH-1:0]  s_i_resptag,
  output logic                 s_i_respcyc,
  input  logic                 s_i_respack,

  input  logic [ADDRWIDTH-1:0] s_d_req,
  input  logic [TAGWIDTH-1:0]  s_d_reqtag,
  input  logic [BLOCKBITS-1:0] s_d_reqdata,
  input  logic                 s_d_reqcyc,
  output logic                 s_d_reqack,
  output logic [BLOCKBITS-1:0] s_d_resp,
  output logic [TAGWIDTH-1:0]  s_d_resptag,
  output logic                 s_d_respcyc,
  input  logic                 s_d_respack,

  output logic [ADDRWIDTH-1:0] m_req,
  output logic [TAGWIDTH-1:0]  m_reqtag,
  output logic [BLOCKBITS-1:0] m_reqdata,
  output logic                 m_reqcyc,
  input  logic                 m_reqack,
  input  logic [BLOCKBITS-1:0] m_resp,
  input  logic [TAGWIDTH-1:0]  m_resptag,
  input  logic                 m_respcyc,
  output logic                 m_respack
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER
  } state_e;

  state_e state_q, state_d;

  // owner: 0 = I side, 1 = D side
  logic owner_q, owner_d;

  logic [ADDRWIDTH-1:0] m_req_q, m_req_d;
  logic [TAGWIDTH-1:0]  m_reqtag_q, m_reqtag_d;
  logic [BLOCKBITS-1:0] m_reqdata_q, m_reqdata_d;
  logic                 m_reqcyc_q, m_reqcyc_d;

  logic                 i_reqack_q, i_reqack_d;
  logic [BLOCKBITS-1:0] i_resp_q, i_resp_d;
  logic [TAGWIDTH-1:0]  i_resptag_q, i_resptag_d;
  logic                 i_respcyc_q, i_respcyc_d;

  logic                 d_reqack_q, d_reqack_d;
  logic [BLOCKBITS-1:0] d_resp_q, d_resp_d;
  logic [TAGWIDTH-1:0]  d_resptag_q, d_resptag_d;
  logic                 d_respcyc_q, d_respcyc_d;

  logic any_req;
  logic gnt_d;
  logic own_respack;

  assign any_req = s_i_reqcyc | s_d_reqcyc;

`ifdef MEMARB_ROUND_ROBIN_EN
  // ptr names the side that wins a tie: 1 = D
  logic ptr_q, ptr_d;

  assign gnt_d = s_d_reqcyc & (~s_i_reqcyc | ptr_q);
`else
  assign gnt_d = s_d_reqcyc;
`endif

  assign own_respack = owner_q ? s_d_respack : s_i_respack;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    m_req_d     = m_req_q;
    m_reqtag_d  = m_reqtag_q;
    m_reqdata_d = m_reqdata_q;
    m_reqcyc_d  = m_reqcyc_q;
    i_reqack_d  = 1'b0;
    d_reqack_d  = 1'b0;
    i_resp_d    = i_resp_q;
    i_resptag_d = i_resptag_q;
    i_respcyc_d = i_respcyc_q;
    d_resp_d    = d_resp_q;
    d_resptag_d = d_resptag_q;
    d_respcyc_d = d_respcyc_q;
`ifdef MEMARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d    = gnt_d;
          m_reqcyc_d = 1'b1;
          state_d    = ISSUE;
          if (gnt_d) begin
            m_req_d     = s_d_req;
            m_reqtag_d  = s_d_reqtag;
            m_reqdata_d = s_d_reqdata;
            d_reqack_d  = 1'b1;
          end else begin
            m_req_d     = s_i_req;
            m_reqtag_d  = s_i_reqtag;
            m_reqdata_d = s_i_reqdata;
            i_reqack_d  = 1'b1;
          end
        end
      end

      ISSUE, WAIT: begin
        // a response also retires the request, even if reqack never came
        if (m_respcyc) begin
          if (owner_q) begin
            d_resp_d    = m_resp;
            d_resptag_d = m_resptag;
            d_respcyc_d = 1'b1;
          end else begin
            i_resp_d    = m_resp;
            i_resptag_d = m_resptag;
            i_respcyc_d = 1'b1;
          end
          m_reqcyc_d = 1'b0;
          state_d    = DELIVER;
        end else if (state_q == ISSUE && m_reqack) begin
          m_reqcyc_d = 1'b0;
          state_d    = WAIT;
        end
      end

      DELIVER: begin
        if (own_respack) begin
          i_respcyc_d = 1'b0;
          d_respcyc_d = 1'b0;
          state_d     = IDLE;
`ifdef MEMARB_ROUND_ROBIN_EN
          ptr_d       = ~owner_q;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      m_req_q     <= '0;
      m_reqtag_q  <= '0;
      m_reqdata_q <= '0;
      m_reqcyc_q  <= 1'b0;
      i_reqack_q  <= 1'b0;
      i_resp_q    <= '0;
      i_resptag_q <= '0;
      i_respcyc_q <= 1'b0;
      d_reqack_q  <= 1'b0;
      d_resp_q    <= '0;
      d_resptag_q <= '0;
      d_respcyc_q <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
      ptr_q       <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      m_req_q     <= m_req_d;
      m_reqtag_q  <= m_reqtag_d;
      m_reqdata_q <= m_reqdata_d;
      m_reqcyc_q  <= m_reqcyc_d;
      i_reqack_q  <= i_reqack_d;
      i_resp_q    <= i_resp_d;
      i_resptag_q <= i_resptag_d;
      i_respcyc_q <= i_respcyc_d;
      d_reqack_q  <= d_reqack_d;
      d_resp_q    <= d_resp_d;
      d_resptag_q <= d_resptag_d;
      d_respcyc_q <= d_respcyc_d;
`ifdef MEMARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign m_req       = m_req_q;
  assign m_reqtag    = m_reqtag_q;
  assign m_reqdata   = m_reqdata_q;
  assign m_reqcyc    = m_reqcyc_q;
  assign m_respack   = m_respcyc &
                       (state_q == ISSUE || state_q == WAIT);

  assign s_i_reqack  = i_reqack_q;
  assign s_i_resp    = i_resp_q;
  assign s_i_resptag = i_resptag_q;
  assign s_i_respcyc = i_respcyc_q;

  assign s_d_reqack  = d_reqack_q;
  assign s_d_resp    = d_resp_q;
  assign s_d_resptag = d_resptag_q;
  assign s_d_respcyc = d_respcyc_q;

endmodule
